processor: RTL and testbench

PROCESSOR -- requirements
Module: processor

---
 rtl/processor.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_processor.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/processor.sv
`default_nettype none

// ============================================================================
// Module      : mem_storage
// Description : Byte-addressed big-endian storage with a combinational word
//               read and a rising-edge word write. Contents are never reset.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_storage #(
    parameter int BYTES = 1024,
    parameter int AW    = $clog2(BYTES)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);
    logic [7:0] bytes [0:BYTES-1];

    logic [AW-1:0] w_a1;
    logic [AW-1:0] w_a2;
    logic [AW-1:0] w_a3;

    // Byte lanes wrap within the array, so a word straddling the top wraps to 0.
    assign w_a1 = i_addr + AW'(1);
    assign w_a2 = i_addr + AW'(2);
    assign w_a3 = i_addr + AW'(3);

    assign o_rdata = {bytes[i_addr], bytes[w_a1], bytes[w_a2], bytes[w_a3]};

    // Word write, most significant byte at the lowest address.
    always_ff @(posedge clk) begin
        if (i_we) begin
            bytes[i_addr] <= i_wdata[31:24];
            bytes[w_a1]   <= i_wdata[23:16];
            bytes[w_a2]   <= i_wdata[15:8];
            bytes[w_a3]   <= i_wdata[7:0];
        end
    end
endmodule

// ============================================================================
// Module      : imemory
// Description : Instruction memory wrapper; read-only from the core's view.
// Revision    : 1.0 - initial release
// ============================================================================
module imemory #(
    parameter int BYTES = 1024,
    parameter int AW    = $clog2(BYTES)
) (
    input  logic          clk,
    input  logic [AW-1:0] i_addr,
    output logic [31:0]   o_instr
);
    mem_storage #(.BYTES(BYTES), .AW(AW)) storage (
        .clk     (clk),
        .i_we    (1'b0),
        .i_addr  (i_addr),
        .i_wdata (32'd0),
        .o_rdata (o_instr)
    );
endmodule

// ============================================================================
// Module      : ifu
// Description : Fetch unit: program counter plus instruction memory.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu #(
    parameter int IMEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_next_pc,
    output logic [31:0] o_pc,
    output logic [31:0] o_instr
);
    localparam int c_aw = $clog2(IMEM_BYTES);

    logic [31:0] r_pc;
    logic        w_unused;

    // PC clears immediately on reset, otherwise advances every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pc <= 32'd0;
        else        r_pc <= i_next_pc;
    end

    // Only the low address bits select a byte; the PC wraps in memory.
    assign w_unused = ^r_pc[31:c_aw];
    assign o_pc     = r_pc;

    imemory #(.BYTES(IMEM_BYTES), .AW(c_aw)) imemory (
        .clk     (clk),
        .i_addr  (r_pc[c_aw-1:0]),
        .o_instr (o_instr)
    );
endmodule

// ============================================================================
// Module      : regfile
// Description : 32 x 32 register file, two combinational reads, one write.
//               Register 0 is hardwired to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata,
    input  logic [4:0]  i_raddr1,
    input  logic [4:0]  i_raddr2,
    output logic [31:0] o_rdata1,
    output logic [31:0] o_rdata2
);
    logic [31:0] registers [0:31];

    // Async clear of every register; writes to $0 are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) registers[i] <= 32'd0;
        end else if (i_we && (i_waddr != 5'd0)) begin
            registers[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = (i_raddr1 == 5'd0) ? 32'd0 : registers[i_raddr1];
    assign o_rdata2 = (i_raddr2 == 5'd0) ? 32'd0 : registers[i_raddr2];
endmodule

// ============================================================================
// Module      : processor
// Description : Single-cycle MIPS32 integer subset core with on-chip
//               instruction and data memories.
// Revision    : 1.0 - initial release
// ============================================================================
module processor #(
    parameter int IMEM_BYTES = 1024,
    parameter int DMEM_BYTES = 1024
) (
    input  logic clk,
    input  logic rst_n
);
    localparam int c_daw = $clog2(DMEM_BYTES);

    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_j     = 6'h02;
    localparam logic [5:0] c_op_jal   = 6'h03;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_bne   = 6'h05;
    localparam logic [5:0] c_op_addi  = 6'h08;
    localparam logic [5:0] c_op_addiu = 6'h09;
    localparam logic [5:0] c_op_slti  = 6'h0A;
    localparam logic [5:0] c_op_sltiu = 6'h0B;
    localparam logic [5:0] c_op_andi  = 6'h0C;
    localparam logic [5:0] c_op_ori   = 6'h0D;
    localparam logic [5:0] c_op_xori  = 6'h0E;
    localparam logic [5:0] c_op_lui   = 6'h0F;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2B;

    logic [31:0] w_pc;
    logic [31:0] w_instr;
    logic [31:0] w_next_pc;
    logic [31:0] w_pc4;
    logic [31:0] w_simm;
    logic [31:0] w_zimm;
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;
    logic [31:0] w_daddr;
    logic [31:0] w_dmem_rdata;
    logic        w_we;
    logic [4:0]  w_waddr;
    logic [31:0] w_wdata;
    logic        w_memwrite;
    logic        w_unused;

    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_shamt;
    logic [5:0]  w_funct;
    logic [15:0] w_imm;
    logic [25:0] w_target;

    assign w_op     = w_instr[31:26];
    assign w_rs     = w_instr[25:21];
    assign w_rt     = w_instr[20:16];
    assign w_rd     = w_instr[15:11];
    assign w_shamt  = w_instr[10:6];
    assign w_funct  = w_instr[5:0];
    assign w_imm    = w_instr[15:0];
    assign w_target = w_instr[25:0];

    assign w_pc4    = w_pc + 32'd4;
    assign w_simm   = {{16{w_imm[15]}}, w_imm};
    assign w_zimm   = {16'd0, w_imm};
    assign w_daddr  = w_rs_val + w_simm;
    assign w_unused = ^w_daddr[31:c_daw];

    ifu #(.IMEM_BYTES(IMEM_BYTES)) IFU (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_next_pc (w_next_pc),
        .o_pc      (w_pc),
        .o_instr   (w_instr)
    );

    regfile registers (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_we     (w_we),
        .i_waddr  (w_waddr),
        .i_wdata  (w_wdata),
        .i_raddr1 (w_rs),
        .i_raddr2 (w_rt),
        .o_rdata1 (w_rs_val),
        .o_rdata2 (w_rt_val)
    );

    // A store is suppressed while reset is held so an aborted sw leaves memory intact.
    mem_storage #(.BYTES(DMEM_BYTES), .AW(c_daw)) dmemory (
        .clk     (clk),
        .i_we    (w_memwrite & rst_n),
        .i_addr  (w_daddr[c_daw-1:0]),
        .i_wdata (w_rt_val),
        .o_rdata (w_dmem_rdata)
    );

    // Decode and execute; unrecognised encodings fall through as no-ops.
    always_comb begin
        w_we       = 1'b0;
        w_waddr    = w_rt;
        w_wdata    = 32'd0;
        w_memwrite = 1'b0;
        w_next_pc  = w_pc4;
        case (w_op)
            c_op_rtype: begin
                w_waddr = w_rd;
                w_we    = 1'b1;
                case (w_funct)
                    6'h20, 6'h21: w_wdata = w_rs_val + w_rt_val;
                    6'h22, 6'h23: w_wdata = w_rs_val - w_rt_val;
                    6'h24:        w_wdata = w_rs_val & w_rt_val;
                    6'h25:        w_wdata = w_rs_val | w_rt_val;
                    6'h26:        w_wdata = w_rs_val ^ w_rt_val;
                    6'h27:        w_wdata = ~(w_rs_val | w_rt_val);
                    6'h2A:        w_wdata = ($signed(w_rs_val) < $signed(w_rt_val)) ? 32'd1 : 32'd0;
                    6'h2B:        w_wdata = (w_rs_val < w_rt_val) ? 32'd1 : 32'd0;
                    6'h00:        w_wdata = w_rt_val << w_shamt;
                    6'h02:        w_wdata = w_rt_val >> w_shamt;
                    6'h03:        w_wdata = $unsigned($signed(w_rt_val) >>> w_shamt);
                    6'h08: begin
                        w_we      = 1'b0;
                        w_next_pc = w_rs_val;
                    end
                    default:      w_we = 1'b0;
                endcase
            end
            c_op_addi, c_op_addiu: begin
                w_we    = 1'b1;
                w_wdata = w_rs_val + w_simm;
            end
            c_op_slti: begin
                w_we    = 1'b1;
                w_wdata = ($signed(w_rs_val) < $signed(w_simm)) ? 32'd1 : 32'd0;
            end
            c_op_sltiu: begin
                w_we    = 1'b1;
                w_wdata = (w_rs_val < w_simm) ? 32'd1 : 32'd0;
            end
            c_op_andi: begin
                w_we    = 1'b1;
                w_wdata = w_rs_val & w_zimm;
            end
            c_op_ori: begin
                w_we    = 1'b1;
                w_wdata = w_rs_val | w_zimm;
            end
            c_op_xori: begin
                w_we    = 1'b1;
                w_wdata = w_rs_val ^ w_zimm;
            end
            c_op_lui: begin
                w_we    = 1'b1;
                w_wdata = {w_imm, 16'd0};
            end
            c_op_lw: begin
                w_we    = 1'b1;
                w_wdata = w_dmem_rdata;
            end
            c_op_sw:  w_memwrite = 1'b1;
            c_op_beq: if (w_rs_val == w_rt_val) w_next_pc = w_pc4 + {w_simm[29:0], 2'b00};
            c_op_bne: if (w_rs_val != w_rt_val) w_next_pc = w_pc4 + {w_simm[29:0], 2'b00};
            c_op_j:   w_next_pc = {w_pc4[31:28], w_target, 2'b00};
            c_op_jal: begin
                w_we      = 1'b1;
                w_waddr   = 5'd31;
                w_wdata   = w_pc4;
                w_next_pc = {w_pc4[31:28], w_target, 2'b00};
            end
            default: ;
        endcase
    end
endmodule

`default_nettype wire

// File: tb/tb_processor.sv
`default_nettype none

// ============================================================================
// Module      : tb_processor
// Description : Directed self-checking bench for the single-cycle core.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_processor;
    logic clk = 1'b0;
    logic rst_n;

    processor #(.IMEM_BYTES(1024), .DMEM_BYTES(1024)) dut (
        .clk   (clk),
        .rst_n (rst_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          kind;   // 0..31 register, 32 PC, 33 data word at address 0
        logic [31:0] exp;
    } chk_t;

    chk_t sb[$];
    int   ntests = 0;
    int   nfail  = 0;

    function automatic logic [31:0] ei(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] er(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [4:0] sh,
                                       input logic [5:0] fn);
        return {6'd0, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] ej(input logic [5:0] op, input logic [25:0] t);
        return {op, t};
    endfunction

    task automatic put(input logic [9:0] a, input logic [31:0] w);
        dut.IFU.imemory.storage.bytes[a]         <= w[31:24];
        dut.IFU.imemory.storage.bytes[a + 10'd1] <= w[23:16];
        dut.IFU.imemory.storage.bytes[a + 10'd2] <= w[15:8];
        dut.IFU.imemory.storage.bytes[a + 10'd3] <= w[7:0];
    endtask

    task automatic expect_val(input string tag, input int kind, input logic [31:0] exp);
        chk_t c;
        c.tag  = tag;
        c.kind = kind;
        c.exp  = exp;
        sb.push_back(c);
    endtask

    function automatic logic [31:0] observe(input int kind);
        logic [4:0] idx;
        idx = kind[4:0];
        if (kind == 32) return dut.IFU.r_pc;
        if (kind == 33) return {dut.dmemory.bytes[0], dut.dmemory.bytes[1],
                                dut.dmemory.bytes[2], dut.dmemory.bytes[3]};
        return dut.registers.registers[idx];
    endfunction

    task automatic drain();
        chk_t        c;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            c   = sb.pop_front();
            obs = observe(c.kind);
            ntests++;
            assert (obs === c.exp)
            else begin
                nfail++;
                $error("FAIL %s observed=%h expected=%h", c.tag, obs, c.exp);
            end
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        put(10'd0,   ei(6'h08, 5'd0, 5'd16, 16'd0));
        put(10'd4,   ei(6'h08, 5'd0, 5'd17, 16'd3));
        put(10'd8,   ei(6'h08, 5'd0, 5'd8,  16'd255));
        put(10'd12,  ei(6'h08, 5'd0, 5'd9,  16'hFFFC));
        put(10'd16,  ei(6'h08, 5'd0, 5'd0,  16'd5));
        put(10'd20,  ei(6'h0F, 5'd0, 5'd8,  16'h1234));
        put(10'd24,  ei(6'h0D, 5'd8, 5'd8,  16'h5678));
        put(10'd28,  ei(6'h2B, 5'd0, 5'd8,  16'd0));
        put(10'd32,  ei(6'h23, 5'd0, 5'd9,  16'd0));
        put(10'd36,  ei(6'h08, 5'd0, 5'd8,  16'h7FFF));
        put(10'd40,  ei(6'h0F, 5'd0, 5'd8,  16'h7FFF));
        put(10'd44,  ei(6'h0D, 5'd8, 5'd8,  16'hFFFF));
        put(10'd48,  ei(6'h08, 5'd8, 5'd8,  16'd1));
        put(10'd52,  er(5'd8,  5'd17, 5'd16, 5'd0, 6'h2A));
        put(10'd56,  er(5'd8,  5'd17, 5'd18, 5'd0, 6'h2B));
        put(10'd60,  er(5'd0,  5'd8,  5'd19, 5'd4, 6'h03));
        put(10'd64,  er(5'd0,  5'd8,  5'd20, 5'd4, 6'h02));
        put(10'd68,  er(5'd0,  5'd0,  5'd21, 5'd0, 6'h27));
        put(10'd72,  er(5'd17, 5'd9,  5'd22, 5'd0, 6'h22));
        put(10'd76,  ei(6'h0E, 5'd0, 5'd23, 16'h8000));
        put(10'd80,  ei(6'h04, 5'd17, 5'd9,  16'd5));
        put(10'd84,  ei(6'h04, 5'd17, 5'd17, 16'd2));
        put(10'd88,  ei(6'h08, 5'd0, 5'd16, 16'd99));
        put(10'd92,  ei(6'h08, 5'd0, 5'd16, 16'd99));
        put(10'd96,  ej(6'h03, 26'd28));
        put(10'd100, 32'hFC00_0000);
        put(10'd104, ej(6'h02, 26'd26));
        put(10'd108, ei(6'h08, 5'd0, 5'd16, 16'd99));
        put(10'd112, ei(6'h05, 5'd0, 5'd0, 16'd1));
        put(10'd116, er(5'd31, 5'd0, 5'd0, 5'd0, 6'h08));

        #1;
        expect_val("rst_pc", 32, 32'd0);
        expect_val("rst_s1", 17, 32'd0);
        expect_val("rst_ra", 31, 32'd0);
        drain();

        @(negedge clk);
        #2 rst_n = 1'b1;

        tick(4);
        expect_val("addi_s0", 16, 32'd0);
        expect_val("addi_s1", 17, 32'd3);
        expect_val("addi_t0", 8,  32'd255);
        expect_val("addi_t1", 9,  32'hFFFF_FFFC);
        expect_val("pc_after4", 32, 32'd16);
        drain();

        tick(1);
        expect_val("zero_reg", 0, 32'd0);
        drain();

        tick(2);
        expect_val("lui_ori_t0", 8, 32'h1234_5678);
        drain();

        tick(2);
        expect_val("lw_t1", 9, 32'h1234_5678);
        expect_val("dmem_word", 33, 32'h1234_5678);
        expect_val("pc_after_lw", 32, 32'd36);
        drain();

        tick(1);
        expect_val("addi_7fff", 8, 32'h0000_7FFF);
        drain();
        tick(2);
        expect_val("max_pos", 8, 32'h7FFF_FFFF);
        drain();
        tick(1);
        expect_val("addi_wrap", 8, 32'h8000_0000);
        drain();

        tick(7);
        expect_val("slt_signed", 16, 32'd1);
        expect_val("sltu_unsigned", 18, 32'd0);
        expect_val("sra", 19, 32'hF800_0000);
        expect_val("srl", 20, 32'h0800_0000);
        expect_val("nor", 21, 32'hFFFF_FFFF);
        expect_val("sub_wrap", 22, 32'hEDCB_A98B);
        expect_val("xori_zext", 23, 32'h0000_8000);
        expect_val("pc_80", 32, 32'd80);
        drain();

        tick(1);
        expect_val("beq_not_taken", 32, 32'd84);
        drain();
        tick(1);
        expect_val("beq_taken", 32, 32'd96);
        drain();
        tick(1);
        expect_val("jal_pc", 32, 32'd112);
        expect_val("jal_ra", 31, 32'd100);
        drain();
        tick(1);
        expect_val("bne_not_taken", 32, 32'd116);
        drain();
        tick(1);
        expect_val("jr_pc", 32, 32'd100);
        drain();
        tick(1);
        expect_val("unknown_nop_pc", 32, 32'd104);
        expect_val("unknown_nop_s0", 16, 32'd1);
        drain();
        tick(2);
        expect_val("j_loop_pc", 32, 32'd104);
        expect_val("skip_s0", 16, 32'd1);
        drain();

        #1 rst_n = 1'b0;
        #1;
        expect_val("async_rst_pc", 32, 32'd0);
        expect_val("async_rst_t0", 8, 32'd0);
        expect_val("async_rst_s1", 17, 32'd0);
        expect_val("dmem_kept", 33, 32'h1234_5678);
        drain();

        @(negedge clk);
        rst_n = 1'b1;
        tick(2);
        expect_val("restart_s1", 17, 32'd3);
        expect_val("restart_t0", 8, 32'd0);
        expect_val("restart_pc", 32, 32'd8);
        drain();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

`default_nettype wire
